// File: rtl/lsu_bus_ctrl_pkg.sv
// Shared definitions for the load/store bus controller: access-size
// encodings, base byte-enable patterns, FSM states and small decode helpers.
package lsu_bus_ctrl_pkg;

  // Access size/sign encodings carried on funct3
  localparam logic [2:0] LSB = 3'b000;
  localparam logic [2:0] LSH = 3'b001;
  localparam logic [2:0] LSW = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  // Byte-enable patterns before lane shifting
  localparam logic [3:0] ONE_BYTE   = 4'b0001;
  localparam logic [3:0] TWO_BYTES  = 4'b0011;
  localparam logic [3:0] FOUR_BYTES = 4'b1111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CMD    = 2'd1,
    RDWAIT = 2'd2,
    DONE   = 2'd3
  } lsuState_e;

  // Unused encodings (011, 110, 111) behave as a full word access
  function automatic logic [2:0] normFunct3(input logic [2:0] f);
    case (f)
      LSB, LSH, LBU, LHU: return f;
      default:            return LSW;
    endcase
  endfunction

  // Unshifted byte enables for a normalised funct3
  function automatic logic [3:0] baseEnable(input logic [2:0] f);
    case (f)
      LSB, LBU: return ONE_BYTE;
      LSH, LHU: return TWO_BYTES;
      default:  return FOUR_BYTES;
    endcase
  endfunction

  // Halfwords need an even offset, words need offset zero
  function automatic logic isMisaligned(input logic [2:0] f, input logic [1:0] off);
    case (f)
      LSH, LHU: return off[0];
      LSW:      return (off != 2'b00);
      default:  return 1'b0;
    endcase
  endfunction

  // Replicate narrow store data across all lanes so any offset finds it
  function automatic logic [31:0] storeLanes(input logic [2:0] f, input logic [31:0] d);
    case (f)
      LSB, LBU: return {4{d[7:0]}};
      LSH, LHU: return {2{d[15:0]}};
      default:  return d;
    endcase
  endfunction

endpackage

// File: rtl/lsu_bus_ctrl_if.sv
// Avalon-MM data master bundle between the controller and the memory fabric.
interface lsu_bus_ctrl_if #(
  parameter int ADDRWIDTH = 32,
  parameter int DATAWIDTH = 32
);

  logic [ADDRWIDTH-1:0] avm_address;
  logic                 avm_read;
  logic                 avm_write;
  logic [3:0]           avm_byteenable;
  logic [DATAWIDTH-1:0] avm_writedata;
  logic [DATAWIDTH-1:0] avm_readdata;
  logic                 avm_waitrequest;
  logic                 avm_readdatavalid;

  modport master (
    output avm_address, avm_read, avm_write, avm_byteenable, avm_writedata,
    input  avm_readdata, avm_waitrequest, avm_readdatavalid
  );

  modport slave (
    input  avm_address, avm_read, avm_write, avm_byteenable, avm_writedata,
    output avm_readdata, avm_waitrequest, avm_readdatavalid
  );

endinterface

// File: rtl/lsu_bus_ctrl_load_align_ext.sv
// Right-aligns the addressed lanes of a 32-bit read word and sign- or
// zero-extends them according to the access size.
module load_align_ext
  import lsu_bus_ctrl_pkg::*;
(
  input  logic [31:0] readdata_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] rdata_o
);

  logic [31:0] shifted;

  // Shift the addressed byte lane down to bit 0, then extend by size
  always_comb begin
    shifted = readdata_i >> {offset_i, 3'b000};
    case (funct3_i)
      LSB:     rdata_o = {{24{shifted[7]}}, shifted[7:0]};
      LSH:     rdata_o = {{16{shifted[15]}}, shifted[15:0]};
      LBU:     rdata_o = {24'd0, shifted[7:0]};
      LHU:     rdata_o = {16'd0, shifted[15:0]};
      default: rdata_o = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_bus_ctrl.sv
// Load/store bus controller: turns one core memory request at a time into an
// Avalon-MM read or write, stalls the core until it finishes, and aborts with
// a bus-error pulse if the slave stops responding.
module lsu_bus_ctrl
  import lsu_bus_ctrl_pkg::*;
#(
  parameter int DATAWIDTH = 32,
  parameter int ADDRWIDTH = 32,
  parameter int TIMEOUT   = 255
) (
  input  logic                 LSUC_CLOCK_50,
  input  logic                 LSUC_RESET_InLow,
  input  logic                 LSUC_Req_In,
  input  logic                 LSUC_Store_In,
  input  logic [2:0]           LSUC_Funct3_InBUS,
  input  logic [ADDRWIDTH-1:0] LSUC_Addr_InBUS,
  input  logic [DATAWIDTH-1:0] LSUC_WData_InBUS,
  output logic [DATAWIDTH-1:0] LSUC_RData_OutBUS,
  output logic                 LSUC_Done_Out,
  output logic                 LSUC_Stall_Out,
  output logic                 LSUC_Misalign_Out,
  output logic                 LSUC_BusErr_Out,
  lsu_bus_ctrl_if.master       avm
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  lsuState_e            state_q, state_d;
  logic [2:0]           funct3_q, funct3_d;
  logic                 store_q, store_d;
  logic [1:0]           offset_q, offset_d;
  logic [ADDRWIDTH-1:0] addr_q, addr_d;
  logic [3:0]           byteEn_q, byteEn_d;
  logic [DATAWIDTH-1:0] wdata_q, wdata_d;
  logic [DATAWIDTH-1:0] rdata_q, rdata_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 busErr_q, busErr_d;

  logic [2:0]  reqFunct3;
  logic        reqMisalign;
  logic        watchdogHit;
  logic [31:0] loadResult;
  logic        stallComb;
  logic        misalignComb;
  logic        doneComb;
  logic        readComb;
  logic        writeComb;

  assign reqFunct3   = normFunct3(LSUC_Funct3_InBUS);
  assign reqMisalign = isMisaligned(reqFunct3, LSUC_Addr_InBUS[1:0]);
  assign watchdogHit = (TIMEOUT != 0) && (cnt_q == LAST_CNT);

  load_align_ext uAlign (
    .readdata_i (avm.avm_readdata),
    .offset_i   (offset_q),
    .funct3_i   (funct3_q),
    .rdata_o    (loadResult)
  );

  // Next-state, datapath capture and handshake outputs for the access FSM
  always_comb begin
    state_d      = state_q;
    funct3_d     = funct3_q;
    store_d      = store_q;
    offset_d     = offset_q;
    addr_d       = addr_q;
    byteEn_d     = byteEn_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    cnt_d        = cnt_q;
    busErr_d     = 1'b0;
    stallComb    = 1'b0;
    misalignComb = 1'b0;
    doneComb     = 1'b0;
    readComb     = 1'b0;
    writeComb    = 1'b0;
    case (state_q)
      IDLE: begin
        if (LSUC_Req_In) begin
          if (reqMisalign) begin
            misalignComb = 1'b1;
          end else begin
            stallComb = 1'b1;
            funct3_d  = reqFunct3;
            store_d   = LSUC_Store_In;
            offset_d  = LSUC_Addr_InBUS[1:0];
            addr_d    = {LSUC_Addr_InBUS[ADDRWIDTH-1:2], 2'b00};
            byteEn_d  = 4'(baseEnable(reqFunct3) << LSUC_Addr_InBUS[1:0]);
            wdata_d   = storeLanes(reqFunct3, LSUC_WData_InBUS);
            cnt_d     = '0;
            state_d   = CMD;
          end
        end
      end
      CMD: begin
        stallComb = 1'b1;
        readComb  = ~store_q;
        writeComb = store_q;
        if (!avm.avm_waitrequest) begin
          if (store_q) begin
            state_d = DONE;
          end else if (avm.avm_readdatavalid) begin
            rdata_d = loadResult;
            state_d = DONE;
          end else begin
            cnt_d   = '0;
            state_d = RDWAIT;
          end
        end else if (watchdogHit) begin
          busErr_d = 1'b1;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RDWAIT: begin
        stallComb = 1'b1;
        if (avm.avm_readdatavalid) begin
          rdata_d = loadResult;
          state_d = DONE;
        end else if (watchdogHit) begin
          busErr_d = 1'b1;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        doneComb = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any access in flight
  always_ff @(posedge LSUC_CLOCK_50 or negedge LSUC_RESET_InLow) begin
    if (!LSUC_RESET_InLow) begin
      state_q  <= IDLE;
      funct3_q <= '0;
      store_q  <= 1'b0;
      offset_q <= '0;
      addr_q   <= '0;
      byteEn_q <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      cnt_q    <= '0;
      busErr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      funct3_q <= funct3_d;
      store_q  <= store_d;
      offset_q <= offset_d;
      addr_q   <= addr_d;
      byteEn_q <= byteEn_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      cnt_q    <= cnt_d;
      busErr_q <= busErr_d;
    end
  end

  // Request-cycle outputs are gated so everything reads 0 while reset is held
  assign LSUC_Stall_Out    = stallComb & LSUC_RESET_InLow;
  assign LSUC_Misalign_Out = misalignComb & LSUC_RESET_InLow;
  assign LSUC_Done_Out     = doneComb;
  assign LSUC_BusErr_Out   = busErr_q;
  assign LSUC_RData_OutBUS = rdata_q;

  assign avm.avm_address    = addr_q;
  assign avm.avm_read       = readComb;
  assign avm.avm_write      = writeComb;
  assign avm.avm_byteenable = byteEn_q;
  assign avm.avm_writedata  = wdata_q;

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Directed bench for lsu_bus_ctrl: stores, loads of every size, wait states,
// misalignment rejection, watchdog aborts and asynchronous reset mid-access.
module tb_lsu_bus_ctrl;
  import lsu_bus_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rstN;
  logic        req;
  logic        store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        done;
  logic        stall;
  logic        misalign;
  logic        busErr;

  int          vecCount = 0;
  int          missCount = 0;
  logic [31:0] lastRdata = 32'h0;

  lsu_bus_ctrl_if #(.ADDRWIDTH(32), .DATAWIDTH(32)) avmBus ();

  lsu_bus_ctrl #(.DATAWIDTH(32), .ADDRWIDTH(32), .TIMEOUT(4)) dut (
    .LSUC_CLOCK_50     (clk),
    .LSUC_RESET_InLow  (rstN),
    .LSUC_Req_In       (req),
    .LSUC_Store_In     (store),
    .LSUC_Funct3_InBUS (funct3),
    .LSUC_Addr_InBUS   (addr),
    .LSUC_WData_InBUS  (wdata),
    .LSUC_RData_OutBUS (rdata),
    .LSUC_Done_Out     (done),
    .LSUC_Stall_Out    (stall),
    .LSUC_Misalign_Out (misalign),
    .LSUC_BusErr_Out   (busErr),
    .avm               (avmBus)
  );

  // 50 MHz clock
  always #10 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vecCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #2;
  endtask

  task automatic idleInputs();
    req    = 1'b0;
    store  = 1'b0;
    funct3 = 3'b000;
    addr   = 32'h0;
    wdata  = 32'h0;
    avmBus.avm_waitrequest   = 1'b0;
    avmBus.avm_readdatavalid = 1'b0;
    avmBus.avm_readdata      = 32'h0;
  endtask

  // Zero-wait access: request, one CMD cycle (data returned same cycle), DONE
  task automatic applyStimulus(input string tag, input logic st, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                               input logic [31:0] expAddr, input logic [3:0] expBe,
                               input logic [31:0] expWd, input logic [31:0] expRd);
    req = 1'b1; store = st; funct3 = f3; addr = a; wdata = wd;
    avmBus.avm_waitrequest = 1'b0;
    #1;
    checkOutput({tag, ".reqStall"}, 32'(stall), 32'h1);
    nextCycle();
    req = 1'b0;
    avmBus.avm_readdatavalid = ~st;
    avmBus.avm_readdata      = rd;
    #1;
    checkOutput({tag, ".cmd"}, 32'({avmBus.avm_read, avmBus.avm_write}), st ? 32'h1 : 32'h2);
    checkOutput({tag, ".addr"}, avmBus.avm_address, expAddr);
    checkOutput({tag, ".be"}, 32'(avmBus.avm_byteenable), 32'(expBe));
    if (st) checkOutput({tag, ".wdata"}, avmBus.avm_writedata, expWd);
    nextCycle();
    avmBus.avm_readdatavalid = 1'b0;
    avmBus.avm_readdata      = 32'h0;
    #1;
    checkOutput({tag, ".done"}, 32'(done), 32'h1);
    checkOutput({tag, ".doneStall"}, 32'(stall), 32'h0);
    if (!st) lastRdata = expRd;
    checkOutput({tag, ".rdata"}, rdata, lastRdata);
    nextCycle();
    #1;
    checkOutput({tag, ".doneEnd"}, 32'(done), 32'h0);
  endtask

  logic [2:0]  misF3   [4] = '{LSW, LSH, LHU, 3'b011};
  logic [31:0] misAddr [4] = '{32'h3001, 32'h0003, 32'h0001, 32'h0002};

  initial begin
    idleInputs();
    rstN = 1'b0;
    #1;
    checkOutput("rst.done", 32'(done), 32'h0);
    checkOutput("rst.stall", 32'(stall), 32'h0);
    checkOutput("rst.cmd", 32'({avmBus.avm_read, avmBus.avm_write}), 32'h0);
    checkOutput("rst.addr", avmBus.avm_address, 32'h0);
    checkOutput("rst.rdata", rdata, 32'h0);
    checkOutput("rst.busErr", 32'(busErr), 32'h0);
    repeat (2) @(posedge clk);
    #2 rstN = 1'b1;
    nextCycle();

    // Store byte at offset 3 with two wait states
    req = 1'b1; store = 1'b1; funct3 = LSB; addr = 32'h1003; wdata = 32'h000000A5;
    avmBus.avm_waitrequest = 1'b1;
    #1;
    checkOutput("sb.reqStall", 32'(stall), 32'h1);
    checkOutput("sb.reqWrite", 32'(avmBus.avm_write), 32'h0);
    nextCycle();
    req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) avmBus.avm_waitrequest = 1'b0;
      #1;
      checkOutput("sb.write", 32'(avmBus.avm_write), 32'h1);
      checkOutput("sb.stall", 32'(stall), 32'h1);
      checkOutput("sb.addr", avmBus.avm_address, 32'h00001000);
      checkOutput("sb.be", 32'(avmBus.avm_byteenable), 32'h8);
      checkOutput("sb.wdata", avmBus.avm_writedata, 32'hA5A5A5A5);
      checkOutput("sb.earlyDone", 32'(done), 32'h0);
      nextCycle();
    end
    #1;
    checkOutput("sb.done", 32'(done), 32'h1);
    checkOutput("sb.doneStall", 32'(stall), 32'h0);
    checkOutput("sb.doneWrite", 32'(avmBus.avm_write), 32'h0);
    nextCycle();
    #1;
    checkOutput("sb.doneEnd", 32'(done), 32'h0);

    // Signed halfword load, data returned 3 cycles after acceptance
    req = 1'b1; store = 1'b0; funct3 = LSH; addr = 32'h2002;
    #1;
    checkOutput("lh.reqStall", 32'(stall), 32'h1);
    nextCycle();
    req = 1'b0;
    #1;
    checkOutput("lh.read", 32'(avmBus.avm_read), 32'h1);
    checkOutput("lh.be", 32'(avmBus.avm_byteenable), 32'hC);
    checkOutput("lh.addr", avmBus.avm_address, 32'h00002000);
    nextCycle();
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin
        avmBus.avm_readdatavalid = 1'b1;
        avmBus.avm_readdata      = 32'h80011234;
      end
      #1;
      checkOutput("lh.waitRead", 32'(avmBus.avm_read), 32'h0);
      checkOutput("lh.waitStall", 32'(stall), 32'h1);
      checkOutput("lh.earlyDone", 32'(done), 32'h0);
      nextCycle();
    end
    avmBus.avm_readdatavalid = 1'b0;
    avmBus.avm_readdata      = 32'h0;
    #1;
    checkOutput("lh.done", 32'(done), 32'h1);
    checkOutput("lh.rdata", rdata, 32'hFFFF8001);
    lastRdata = 32'hFFFF8001;
    nextCycle();
    #1;
    checkOutput("lh.doneEnd", 32'(done), 32'h0);
    checkOutput("lh.rdataHold", rdata, 32'hFFFF8001);

    // Zero-wait directed vectors
    applyStimulus("lbu0",  1'b0, LBU,    32'h00000010, 32'h0,        32'h000000F0, 32'h00000010, 4'h1, 32'h0,        32'h000000F0);
    applyStimulus("sw",    1'b1, LSW,    32'h00000008, 32'hDEADBEEF, 32'h0,        32'h00000008, 4'hF, 32'hDEADBEEF, 32'h0);
    applyStimulus("shHi",  1'b1, LSH,    32'h00000006, 32'h1234BEEF, 32'h0,        32'h00000004, 4'hC, 32'hBEEFBEEF, 32'h0);
    applyStimulus("lbNeg", 1'b0, LSB,    32'h00000013, 32'h0,        32'h80FFFFFF, 32'h00000010, 4'h8, 32'h0,        32'hFFFFFF80);
    applyStimulus("lhu",   1'b0, LHU,    32'h00000022, 32'h0,        32'h80011234, 32'h00000020, 4'hC, 32'h0,        32'h00008001);
    applyStimulus("lhPos", 1'b0, LSH,    32'h00000030, 32'h0,        32'h80017FFE, 32'h00000030, 4'h3, 32'h0,        32'h00007FFE);
    applyStimulus("lw111", 1'b0, 3'b111, 32'h00000044, 32'h0,        32'h12345678, 32'h00000044, 4'hF, 32'h0,        32'h12345678);
    applyStimulus("lbuL1", 1'b0, LBU,    32'h00000015, 32'h0,        32'h0000AB00, 32'h00000014, 4'h2, 32'h0,        32'h000000AB);
    applyStimulus("lbPos", 1'b0, LSB,    32'h0000000E, 32'h0,        32'h007F0000, 32'h0000000C, 4'h4, 32'h0,        32'h0000007F);
    applyStimulus("sbL1",  1'b1, LSB,    32'h00000101, 32'h0000003C, 32'h0,        32'h00000100, 4'h2, 32'h3C3C3C3C, 32'h0);

    // Misaligned requests are rejected without touching the bus
    for (int i = 0; i < 4; i++) begin
      req = 1'b1; store = 1'b0; funct3 = misF3[i]; addr = misAddr[i];
      #1;
      checkOutput("mis.pulse", 32'(misalign), 32'h1);
      checkOutput("mis.stall", 32'(stall), 32'h0);
      nextCycle();
      req = 1'b0;
      #1;
      checkOutput("mis.pulseEnd", 32'(misalign), 32'h0);
      checkOutput("mis.cmd", 32'({avmBus.avm_read, avmBus.avm_write}), 32'h0);
      checkOutput("mis.idleStall", 32'(stall), 32'h0);
      nextCycle();
    end

    // Watchdog abort while the slave holds waitrequest
    req = 1'b1; store = 1'b0; funct3 = LSW; addr = 32'h40;
    avmBus.avm_waitrequest = 1'b1;
    #1;
    checkOutput("wdCmd.reqStall", 32'(stall), 32'h1);
    nextCycle();
    req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checkOutput("wdCmd.read", 32'(avmBus.avm_read), 32'h1);
      checkOutput("wdCmd.earlyErr", 32'(busErr), 32'h0);
      nextCycle();
    end
    #1;
    checkOutput("wdCmd.busErr", 32'(busErr), 32'h1);
    checkOutput("wdCmd.readDrop", 32'(avmBus.avm_read), 32'h0);
    checkOutput("wdCmd.noDone", 32'(done), 32'h0);
    checkOutput("wdCmd.stall", 32'(stall), 32'h0);
    checkOutput("wdCmd.rdata", rdata, lastRdata);
    avmBus.avm_waitrequest = 1'b0;
    nextCycle();
    #1;
    checkOutput("wdCmd.busErrEnd", 32'(busErr), 32'h0);
    checkOutput("wdCmd.noDoneLate", 32'(done), 32'h0);
    applyStimulus("afterWd", 1'b0, LSW, 32'h00000048, 32'h0, 32'hA1B2C3D4, 32'h00000048, 4'hF, 32'h0, 32'hA1B2C3D4);

    // Watchdog abort while waiting for read data
    req = 1'b1; store = 1'b0; funct3 = LSW; addr = 32'h4C;
    nextCycle();
    req = 1'b0;
    #1;
    checkOutput("wdRd.read", 32'(avmBus.avm_read), 32'h1);
    nextCycle();
    for (int i = 0; i < 4; i++) begin
      #1;
      checkOutput("wdRd.waitStall", 32'(stall), 32'h1);
      checkOutput("wdRd.earlyErr", 32'(busErr), 32'h0);
      nextCycle();
    end
    #1;
    checkOutput("wdRd.busErr", 32'(busErr), 32'h1);
    checkOutput("wdRd.noDone", 32'(done), 32'h0);
    checkOutput("wdRd.rdata", rdata, lastRdata);
    nextCycle();

    // Asynchronous reset in the middle of a read wait
    req = 1'b1; store = 1'b0; funct3 = LSW; addr = 32'h50;
    nextCycle();
    req = 1'b0;
    nextCycle();
    #1;
    checkOutput("rstMid.waitStall", 32'(stall), 32'h1);
    rstN = 1'b0;
    req  = 1'b1;
    #1;
    checkOutput("rstMid.stall", 32'(stall), 32'h0);
    checkOutput("rstMid.done", 32'(done), 32'h0);
    checkOutput("rstMid.cmd", 32'({avmBus.avm_read, avmBus.avm_write}), 32'h0);
    checkOutput("rstMid.addr", avmBus.avm_address, 32'h0);
    checkOutput("rstMid.be", 32'(avmBus.avm_byteenable), 32'h0);
    checkOutput("rstMid.rdata", rdata, 32'h0);
    checkOutput("rstMid.busErr", 32'(busErr), 32'h0);
    lastRdata = 32'h0;
    nextCycle();
    req  = 1'b0;
    rstN = 1'b1;
    avmBus.avm_readdatavalid = 1'b1;
    avmBus.avm_readdata      = 32'hCAFEF00D;
    #1;
    checkOutput("rstMid.lateDone", 32'(done), 32'h0);
    nextCycle();
    avmBus.avm_readdatavalid = 1'b0;
    #1;
    checkOutput("rstMid.lateDone2", 32'(done), 32'h0);
    checkOutput("rstMid.lateRdata", rdata, 32'h0);
    checkOutput("rstMid.idleStall", 32'(stall), 32'h0);
    nextCycle();
    applyStimulus("afterRst", 1'b0, LHU, 32'h00000062, 32'h0, 32'hFEDC0000, 32'h00000060, 4'hC, 32'h0, 32'h0000FEDC);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
